memory_stage: RTL and testbench

Y86-64 SEQ memory stage. It sits directly downstream of the execute stage and consumes vale, vala, valp and icode. It performs the instruction's data-memory read or write against an internal byte-addressed little-endian data memory, then returns valm and stat to write-back/PC-update. Access uses a valid/ready handshake with a parameterised access latency, so execute and write-back can stall on slow memory.

---
 rtl/memory_stage.sv | 136 +++++++++++++
 tb/tb_memory_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: quadword read/write of an internal little-endian data memory
// behind a valid/ready handshake. Optional macro DMEM_ALIGN_CHECK_EN makes unaligned accesses errors.
module memory_stage #(
  parameter int DMEM_BYTES  = 4096,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] vale,
  input  logic [63:0] vala,
  input  logic [63:0] valp,
  input  logic        instr_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] valm,
  output logic [2:0]  stat,
  output logic        dmem_error,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its data stable until that edge, the consumer must not depend on it after.
  localparam int AW = $clog2(DMEM_BYTES);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [63:0] LAST_ADDR = 64'(DMEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      icode_q;
  logic [63:0]     vale_q, vala_q, valp_q;
  logic            iv_q;
  logic [7:0]      mem [DMEM_BYTES];

  logic            is_read, is_write, addr_err, access_now;
  logic [63:0]     addr, wdata, rdata;
  logic [AW-1:0]   base;
  logic [2:0]      stat_d;

  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    addr     = vale_q;
    wdata    = vala_q;
    case (icode_q)
      4'd4:  is_write = 1'b1;
      4'd5:  is_read  = 1'b1;
      4'd8:  begin is_write = 1'b1; wdata = valp_q; end
      4'd9:  begin is_read  = 1'b1; addr  = vala_q; end
      4'd10: is_write = 1'b1;
      4'd11: begin is_read  = 1'b1; addr  = vala_q; end
      default: ;
    endcase
  end

  always_comb begin
    addr_err = (is_read || is_write) && (addr > LAST_ADDR);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((is_read || is_write) && (addr[2:0] != 3'd0)) addr_err = 1'b1;
`endif
  end

  // Byte index wraps within the memory; only in-range results are ever used.
  assign base = addr[AW-1:0];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem[base + AW'(i)];
  end

  always_comb begin
    if (!iv_q)          stat_d = 3'd4;
    else if (addr_err)  stat_d = 3'd3;
    else if (icode_q == 4'd0) stat_d = 3'd2;
    else                stat_d = 3'd1;
  end

  assign access_now = (state_q == ACCESS) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      icode_q    <= '0;
      vale_q     <= '0;
      vala_q     <= '0;
      valp_q     <= '0;
      iv_q       <= 1'b0;
      valm       <= '0;
      stat       <= 3'd1;
      dmem_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        cnt_q   <= CW'(MEM_LATENCY - 1);
        icode_q <= icode;
        vale_q  <= vale;
        vala_q  <= vala;
        valp_q  <= valp;
        iv_q    <= instr_valid;
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (access_now) begin
        valm       <= (is_read && !addr_err) ? rdata : 64'd0;
        stat       <= stat_d;
        dmem_error <= addr_err;
      end
    end
  end

  // Storage is deliberately not reset; reset only stops the write by leaving ACCESS.
  always_ff @(posedge clock) begin
    if (access_now && is_write && !addr_err)
      for (int i = 0; i < 8; i++) mem[base + AW'(i)] <= wdata[8*i +: 8];
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: three instances (latency 1, 3, 4) against a byte-array reference model.
module tb_memory_stage;
  localparam int DMEM = 4096;
  localparam int N = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid [N];
  logic        in_ready [N];
  logic [3:0]  icode [N];
  logic [63:0] vale [N];
  logic [63:0] vala [N];
  logic [63:0] valp [N];
  logic        instr_valid [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [63:0] valm [N];
  logic [2:0]  stat [N];
  logic        dmem_error [N];
  logic [1:0]  dbg_state [N];

  logic [7:0]  ref_mem [N][DMEM];
  logic [67:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    memory_stage #(.DMEM_BYTES(DMEM), .MEM_LATENCY(L)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .icode(icode[g]), .vale(vale[g]), .vala(vala[g]), .valp(valp[g]),
      .instr_valid(instr_valid[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .valm(valm[g]), .stat(stat[g]), .dmem_error(dmem_error[g]),
      .dbg_state(dbg_state[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: quadword semantics straight from the instruction set rules.
  task automatic model_op(input int d, input logic [3:0] ic, input logic [63:0] ve, va, vp,
                          input logic iv, output logic [67:0] res);
    logic rd, wr, e;
    logic [63:0] a, wd, m;
    logic [2:0] s;
    rd = (ic == 5 || ic == 9 || ic == 11);
    wr = (ic == 4 || ic == 8 || ic == 10);
    a  = (ic == 9 || ic == 11) ? va : ve;
    wd = (ic == 8) ? vp : va;
    e  = (rd || wr) && (a > 64'(DMEM - 8));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((rd || wr) && a[2:0] != 3'd0) e = 1'b1;
`endif
    m = 64'd0;
    if (rd && !e) for (int i = 0; i < 8; i++) m[8*i +: 8] = ref_mem[d][int'(a) + i];
    if (wr && !e) for (int i = 0; i < 8; i++) ref_mem[d][int'(a) + i] = wd[8*i +: 8];
    s = !iv ? 3'd4 : e ? 3'd3 : (ic == 0) ? 3'd2 : 3'd1;
    res = {e, s, m};
  endtask

  task automatic run_op(input int d, input logic [3:0] ic, input logic [63:0] ve, va, vp,
                        input logic iv, input int hold, input string tag);
    logic [67:0] r, exp;
    logic [63:0] held;
    int lat;
    model_op(d, ic, ve, va, vp, iv, r);
    exp_q.push_back(r);
    @(negedge clock);
    icode[d] = ic; vale[d] = ve; vala[d] = va; valp[d] = vp; instr_valid[d] = iv;
    in_valid[d] = 1'b1; out_ready[d] = 1'b0;
    check({tag, ":in_ready_idle"}, 64'(in_ready[d]), 64'd1);
    @(posedge clock); #1;
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 40) begin
      check({tag, ":in_ready_busy"}, 64'(in_ready[d]), 64'd0);
      @(posedge clock); #1;
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'(lat_of(d)));
    exp = exp_q.pop_front();
    check({tag, ":valm"}, valm[d], exp[63:0]);
    check({tag, ":stat"}, 64'(stat[d]), 64'(exp[66:64]));
    check({tag, ":dmem_error"}, 64'(dmem_error[d]), 64'(exp[67]));
    held = valm[d];
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      check({tag, ":hold_valid"}, 64'(out_valid[d]), 64'd1);
      check({tag, ":hold_valm"}, valm[d], held);
      check({tag, ":hold_in_ready"}, 64'(in_ready[d]), 64'd0);
    end
    @(negedge clock); out_ready[d] = 1'b1;
    @(posedge clock); #1; out_ready[d] = 1'b0;
    check({tag, ":out_valid_drop"}, 64'(out_valid[d]), 64'd0);
    check({tag, ":back_idle"}, 64'(in_ready[d]), 64'd1);
  endtask

  initial begin
    logic [63:0] a, v, old80;
    logic [3:0] ic;
    int d;
    for (int k = 0; k < N; k++) begin
      in_valid[k] = 0; icode[k] = 0; vale[k] = 0; vala[k] = 0; valp[k] = 0;
      instr_valid[k] = 1; out_ready[k] = 0;
      for (int i = 0; i < DMEM; i++) ref_mem[k][i] = 8'h00;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < N; k++) begin
      check("reset:in_ready", 64'(in_ready[k]), 64'd1);
      check("reset:out_valid", 64'(out_valid[k]), 64'd0);
      check("reset:valm", valm[k], 64'd0);
      check("reset:stat", 64'(stat[k]), 64'd1);
      check("reset:dmem_error", 64'(dmem_error[k]), 64'd0);
    end
    @(negedge clock); reset_n = 1'b1;

    // Give every byte the random paths may read a known value.
    for (int k = 0; k < N; k++) begin
      for (int q = 0; q < 128; q++) run_op(k, 4, 64'(q * 8), {$urandom, $urandom}, 0, 1, 0, "init");
      run_op(k, 4, 64'(DMEM - 8), 64'hA5A5_0000_1234_5678, 0, 1, 0, "init_top");
    end

    run_op(0, 4, 64'h100, 64'h1122334455667788, 0, 1, 0, "rmmovq");
    run_op(0, 5, 64'h100, 0, 0, 1, 1, "mrmovq");
    check("byte_lsb", 64'(ref_mem[0][32'h100]), 64'h88);
    run_op(0, 4, 64'h0FC, 64'h0, 0, 1, 0, "clr_neighbor");
    run_op(0, 5, 64'h100, 0, 0, 1, 0, "lsb_after_neighbor");
    run_op(0, 8, 64'h1F8, 0, 64'h40, 1, 0, "call");
    run_op(0, 9, 0, 64'h1F8, 0, 1, 0, "ret");
    run_op(2, 4, 64'h200, 64'hDEAD_BEEF_CAFE_F00D, 0, 1, 3, "lat4_write");
    run_op(2, 5, 64'h200, 0, 0, 1, 3, "lat4_read");

    for (int k = 0; k < N; k++) begin
      run_op(k, 5, 64'(DMEM - 7), 0, 0, 1, 0, "oob_read");
      run_op(k, 4, 64'(DMEM - 7), 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, "oob_write");
      run_op(k, 5, 64'(DMEM - 8), 0, 0, 1, 0, "top_read");
      run_op(k, 10, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 0, 1, 0, "huge_push");
    end

    run_op(0, 0, 0, 0, 0, 1, 0, "halt");
    run_op(0, 5, 64'h100, 0, 0, 0, 0, "ins");
    run_op(0, 4, 64'h103, 64'h0102030405060708, 0, 1, 0, "unaligned_write");
    run_op(0, 5, 64'h100, 0, 0, 1, 0, "unaligned_verify_lo");
    run_op(0, 5, 64'h108, 0, 0, 1, 0, "unaligned_verify_hi");

    // Reset while a pushq is still counting down: no write may land.
    run_op(1, 4, 64'h80, 64'h5555_6666_7777_8888, 0, 1, 0, "pre_push");
    old80 = 64'h5555_6666_7777_8888;
    @(negedge clock);
    icode[1] = 4'd10; vale[1] = 64'h80; vala[1] = 64'h0BAD_0BAD_0BAD_0BAD; instr_valid[1] = 1;
    in_valid[1] = 1'b1;
    @(posedge clock); #1; in_valid[1] = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0; #2;
    check("rst_mid:out_valid", 64'(out_valid[1]), 64'd0);
    check("rst_mid:in_ready", 64'(in_ready[1]), 64'd1);
    check("rst_mid:stat", 64'(stat[1]), 64'd1);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("rst_mid:stay_idle", 64'(out_valid[1]), 64'd0);
    run_op(1, 5, 64'h80, 0, 0, 1, 0, "rst_mid_read");
    check("rst_mid:model_kept", {ref_mem[1][32'h87], ref_mem[1][32'h86], ref_mem[1][32'h85],
          ref_mem[1][32'h84], ref_mem[1][32'h83], ref_mem[1][32'h82], ref_mem[1][32'h81],
          ref_mem[1][32'h80]}, old80);

    for (int t = 0; t < 200; t++) begin
      d  = $urandom_range(0, N - 1);
      ic = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 32'h3F0));
      v  = {$urandom, $urandom};
      if (ic == 9 || ic == 11) run_op(d, ic, v, a, {$urandom, $urandom},
                                      ($urandom_range(0, 7) != 0), $urandom_range(0, 3), "rand");
      else run_op(d, ic, a, v, {$urandom, $urandom},
                  ($urandom_range(0, 7) != 0), $urandom_range(0, 3), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
